// File: rtl/noc_pkg.sv
// Shared definitions for the HNoC endpoint: flit geometry, skid-buffer state
// encoding and the destination-field extractor.
package noc_pkg;

   localparam int unsigned DATA_WIDTH = 36;
   localparam int unsigned ADDR_WIDTH = 4;

   typedef enum logic [0:0] {
      StEmptyOrMain,
      StSkid
   } skid_state_e;

   // The destination occupies the most significant ADDR_WIDTH bits of a flit.
   function automatic logic [ADDR_WIDTH-1:0] flit_dest(input logic [DATA_WIDTH-1:0] flit);
      return ADDR_WIDTH'(flit >> (DATA_WIDTH - ADDR_WIDTH));
   endfunction

endpackage

// File: rtl/noc_skid_buffer.sv
// Two-entry skid buffer with a registered upstream ready. The main register
// drives the outputs; the skid register catches the word that arrives while
// downstream is stalling.
module noc_skid_buffer
   import noc_pkg::*;
#(
   parameter int unsigned Width = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [Width-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [Width-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready
);

   skid_state_e      state_q, state_d;
   logic             main_valid_q, main_valid_d;
   logic [Width-1:0] main_data_q, main_data_d;
   logic [Width-1:0] skid_data_q, skid_data_d;
   logic             ready_q, ready_d;
   logic             in_fire;
   logic             out_fire;

   assign in_fire  = i_valid & ready_q;
   assign out_fire = main_valid_q & i_ready;

   // Next-state: load main when it is free or draining, otherwise park in skid.
   always_comb begin
      state_d      = state_q;
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      unique case (state_q)
         StEmptyOrMain: begin
            if (!main_valid_q || out_fire) begin
               main_valid_d = in_fire;
               if (in_fire) begin
                  main_data_d = i_data;
               end
            end else if (in_fire) begin
               skid_data_d = i_data;
               state_d     = StSkid;
            end
         end
         StSkid: begin
            // Upstream ready is low here, so no new word can arrive.
            if (out_fire) begin
               main_data_d = skid_data_q;
               state_d     = StEmptyOrMain;
            end
         end
         default: state_d = StEmptyOrMain;
      endcase
      ready_d = (state_d == StEmptyOrMain);
   end

   // State and data registers; ready stays low throughout reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= StEmptyOrMain;
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
         ready_q      <= ready_d;
      end
   end

   assign o_ready = ready_q;
   assign o_data  = main_data_q;
   assign o_valid = main_valid_q;

endmodule

// File: rtl/noc_endpoint.sv
// HNoC endpoint: tags PE payloads with a destination on the way out, filters
// and strips incoming flits on the way in. Each direction has its own skid
// buffer. Optional statistics counters are enabled by NOC_EP_STATS_EN.
module noc_endpoint
   import noc_pkg::*;
#(
   parameter int unsigned DataWidth = DATA_WIDTH,
   parameter int unsigned AddrWidth = ADDR_WIDTH,
   parameter int unsigned MyAddr    = 0,
   parameter int unsigned StatWidth = 16
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
   input  logic [AddrWidth-1:0]           i_pe_dest,
   input  logic                           i_pe_valid,
   output logic                           o_pe_ready,
   output logic [DataWidth-1:0]           o_data,
   output logic                           o_data_valid,
   input  logic                           i_data_ready,
   input  logic [DataWidth-1:0]           i_data,
   input  logic                           i_data_valid,
   output logic                           o_data_ready,
   output logic [DataWidth-AddrWidth-1:0] o_pe_data,
   output logic                           o_pe_valid,
   input  logic                           i_pe_ready,
`ifdef NOC_EP_STATS_EN
   output logic [StatWidth-1:0]           o_tx_count,
   output logic [StatWidth-1:0]           o_rx_count,
   output logic [StatWidth-1:0]           o_drop_count,
`endif
   output logic                           o_rx_drop
);

   localparam int unsigned PW = DataWidth - AddrWidth;

   logic rx_match;
   logic rx_drop_fire;
   logic rx_drop_q;

   noc_skid_buffer #(
      .Width(DataWidth)
   ) u_tx_buf (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_data ({i_pe_dest, i_pe_data}),
      .i_valid(i_pe_valid),
      .o_ready(o_pe_ready),
      .o_data (o_data),
      .o_valid(o_data_valid),
      .i_ready(i_data_ready)
   );

   assign rx_match     = (flit_dest(i_data) == AddrWidth'(MyAddr));
   // Misrouted flits are still accepted, they just never enter the buffer.
   assign rx_drop_fire = i_data_valid & o_data_ready & ~rx_match;

   noc_skid_buffer #(
      .Width(PW)
   ) u_rx_buf (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_data (i_data[PW-1:0]),
      .i_valid(i_data_valid & rx_match),
      .o_ready(o_data_ready),
      .o_data (o_pe_data),
      .o_valid(o_pe_valid),
      .i_ready(i_pe_ready)
   );

   // Drop pulse appears the cycle after the misrouted flit is accepted.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rx_drop_q <= 1'b0;
      end else begin
         rx_drop_q <= rx_drop_fire;
      end
   end

   assign o_rx_drop = rx_drop_q;

`ifdef NOC_EP_STATS_EN
   logic [StatWidth-1:0] tx_cnt_q, tx_cnt_d;
   logic [StatWidth-1:0] rx_cnt_q, rx_cnt_d;
   logic [StatWidth-1:0] drop_cnt_q, drop_cnt_d;

   // Saturating event counters.
   always_comb begin
      tx_cnt_d   = tx_cnt_q;
      rx_cnt_d   = rx_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (o_data_valid && i_data_ready && (tx_cnt_q != '1)) begin
         tx_cnt_d = tx_cnt_q + StatWidth'(1);
      end
      if (o_pe_valid && i_pe_ready && (rx_cnt_q != '1)) begin
         rx_cnt_d = rx_cnt_q + StatWidth'(1);
      end
      if (rx_drop_fire && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + StatWidth'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign o_tx_count   = tx_cnt_q;
   assign o_rx_count   = rx_cnt_q;
   assign o_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_endpoint.sv
// Bench for noc_endpoint: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_noc_endpoint;

   localparam int DW   = 36;
   localparam int AW   = 4;
   localparam int PW   = 32;
   localparam int SW   = 4;
   localparam int SMAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] pe_data;
   logic [AW-1:0] pe_dest;
   logic          pe_valid;
   logic          pe_ready_o;
   logic [DW-1:0] data_o;
   logic          data_valid_o;
   logic          data_ready;
   logic [DW-1:0] data_i;
   logic          data_valid;
   logic          data_ready_o;
   logic [PW-1:0] pe_data_o;
   logic          pe_valid_o;
   logic          pe_ready;
   logic          rx_drop_o;
`ifdef NOC_EP_STATS_EN
   logic [SW-1:0] tx_count_o;
   logic [SW-1:0] rx_count_o;
   logic [SW-1:0] drop_count_o;
`endif

   always #5 clk = ~clk;

   noc_endpoint #(
      .DataWidth(DW),
      .AddrWidth(AW),
      .MyAddr   (0),
`ifdef NOC_EP_STATS_EN
      .StatWidth(SW)
`else
      .StatWidth(16)
`endif
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_pe_data   (pe_data),
      .i_pe_dest   (pe_dest),
      .i_pe_valid  (pe_valid),
      .o_pe_ready  (pe_ready_o),
      .o_data      (data_o),
      .o_data_valid(data_valid_o),
      .i_data_ready(data_ready),
      .i_data      (data_i),
      .i_data_valid(data_valid),
      .o_data_ready(data_ready_o),
      .o_pe_data   (pe_data_o),
      .o_pe_valid  (pe_valid_o),
      .i_pe_ready  (pe_ready),
`ifdef NOC_EP_STATS_EN
      .o_tx_count  (tx_count_o),
      .o_rx_count  (rx_count_o),
      .o_drop_count(drop_count_o),
`endif
      .o_rx_drop   (rx_drop_o)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO contents per direction, nothing about registers.
   logic [DW-1:0] txq[$];
   logic [PW-1:0] rxq[$];
   bit            model_on = 1'b0;
   bit            rst_last = 1'b1;
   bit            drop_exp = 1'b0;
   int            txc, rxc, dropc;

   always @(posedge clk) begin
      if (rst) begin
         txq.delete();
         rxq.delete();
         rst_last = 1'b1;
         drop_exp = 1'b0;
         txc      = 0;
         rxc      = 0;
         dropc    = 0;
         model_on = 1'b1;
      end else if (model_on) begin
         if (data_valid_o && data_ready) begin
            if (txq.size() != 0) void'(txq.pop_front());
            txc = (txc == SMAX) ? SMAX : txc + 1;
         end
         if (pe_valid && pe_ready_o) txq.push_back({pe_dest, pe_data});
         if (pe_valid_o && pe_ready) begin
            if (rxq.size() != 0) void'(rxq.pop_front());
            rxc = (rxc == SMAX) ? SMAX : rxc + 1;
         end
         drop_exp = 1'b0;
         if (data_valid && data_ready_o) begin
            if (data_i[DW-1 -: AW] == '0) begin
               rxq.push_back(data_i[PW-1:0]);
            end else begin
               drop_exp = 1'b1;
               dropc    = (dropc == SMAX) ? SMAX : dropc + 1;
            end
         end
         rst_last = 1'b0;
      end
   end

   // Compare DUT against the model mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (model_on) begin
         chk("tx_valid", data_valid_o, txq.size() != 0);
         if (txq.size() != 0) chk("tx_data", data_o, txq[0]);
         chk("tx_ready", pe_ready_o, !rst_last && txq.size() < 2);
         chk("rx_valid", pe_valid_o, rxq.size() != 0);
         if (rxq.size() != 0) chk("rx_data", pe_data_o, rxq[0]);
         chk("rx_ready", data_ready_o, !rst_last && rxq.size() < 2);
         chk("rx_drop", rx_drop_o, drop_exp);
`ifdef NOC_EP_STATS_EN
         chk("tx_count", tx_count_o, txc);
         chk("rx_count", rx_count_o, rxc);
         chk("drop_count", drop_count_o, dropc);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] stream_word(input int k);
      logic [AW-1:0] d;
      d = AW'(k + 1);
      return {d, 32'hA000_0000 + 32'(k)};
   endfunction

   initial begin
      int  idx, got;
      bit  saw, acc;
      rst        = 1'b1;
      pe_data    = '0;
      pe_dest    = '0;
      pe_valid   = 1'b0;
      data_ready = 1'b0;
      data_i     = '0;
      data_valid = 1'b0;
      pe_ready   = 1'b0;
      repeat (2) step();
      chk("rst_pe_ready", pe_ready_o, 1'b0);
      chk("rst_data_ready", data_ready_o, 1'b0);
      chk("rst_data_valid", data_valid_o, 1'b0);
      chk("rst_pe_valid", pe_valid_o, 1'b0);
      chk("rst_data", data_o, '0);
      chk("rst_pe_data", pe_data_o, '0);
      chk("rst_drop", rx_drop_o, 1'b0);
      rst = 1'b0;
      step();
      chk("rel_pe_ready", pe_ready_o, 1'b1);
      chk("rel_data_ready", data_ready_o, 1'b1);

      // TX tagging.
      pe_valid   = 1'b1;
      pe_dest    = 4'd5;
      pe_data    = 32'hDEAD_BEEF;
      data_ready = 1'b1;
      step();
      pe_valid = 1'b0;
      chk("tx_flit", data_o, 36'h5_DEAD_BEEF);
      chk("tx_flit_valid", data_valid_o, 1'b1);
      step();

      // RX delivery to this endpoint.
      data_i     = 36'h0_0000_1234;
      data_valid = 1'b1;
      pe_ready   = 1'b1;
      step();
      data_valid = 1'b0;
      chk("rx_payload", pe_data_o, 32'h1234);
      chk("rx_payload_valid", pe_valid_o, 1'b1);
      chk("rx_no_drop", rx_drop_o, 1'b0);

      // Misrouted flit.
      data_i     = 36'h3_0000_1234;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      chk("drop_pulse", rx_drop_o, 1'b1);
      chk("drop_no_valid", pe_valid_o, 1'b0);
`ifdef NOC_EP_STATS_EN
      chk("drop_count_one", drop_count_o, 1);
`endif
      step();
      chk("drop_pulse_end", rx_drop_o, 1'b0);

      // Stream of 8 TX words with downstream stalled in cycles 2-4.
      idx = 0;
      got = 0;
      saw = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         data_ready = !(c >= 2 && c <= 4);
         pe_valid   = (idx < 8);
         {pe_dest, pe_data} = stream_word(idx);
         if (!pe_ready_o && !saw) begin
            saw = 1'b1;
            chk("stall_after_words", idx, 2);
         end
         acc = pe_valid && pe_ready_o;
         if (data_valid_o && data_ready) begin
            if (got < 8) chk("stream_order", data_o, stream_word(got));
            got++;
         end
         step();
         if (acc) idx++;
      end
      pe_valid = 1'b0;
      chk("stream_stalled", saw, 1'b1);
      chk("stream_count", got, 8);

      // Fill both buffers, then reset.
      data_ready = 1'b0;
      pe_ready   = 1'b0;
      pe_valid   = 1'b1;
      data_valid = 1'b1;
      data_i     = 36'h0_1111_2222;
      repeat (3) step();
      chk("full_pe_ready", pe_ready_o, 1'b0);
      chk("full_data_ready", data_ready_o, 1'b0);
      pe_valid   = 1'b0;
      data_valid = 1'b0;
      rst        = 1'b1;
      step();
      chk("mid_rst_tx_valid", data_valid_o, 1'b0);
      chk("mid_rst_rx_valid", pe_valid_o, 1'b0);
      chk("mid_rst_pe_ready", pe_ready_o, 1'b0);
      chk("mid_rst_data_ready", data_ready_o, 1'b0);
      rst = 1'b0;
      step();
      chk("post_rst_pe_ready", pe_ready_o, 1'b1);
      chk("post_rst_data_ready", data_ready_o, 1'b1);

`ifdef NOC_EP_STATS_EN
      // Counter saturation.
      data_ready = 1'b1;
      pe_valid   = 1'b1;
      repeat (20) step();
      pe_valid = 1'b0;
      step();
      chk("tx_count_sat", tx_count_o, 4'd15);
`endif

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         pe_valid   = $urandom_range(0, 1);
         pe_dest    = AW'($urandom);
         pe_data    = $urandom;
         data_ready = ($urandom_range(0, 3) != 0);
         data_valid = $urandom_range(0, 1);
         data_i     = {($urandom_range(0, 1) != 0) ? 4'd0 : AW'($urandom), 32'($urandom)};
         pe_ready   = ($urandom_range(0, 3) != 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_endpoint.md
# noc_endpoint

Network endpoint that joins one processing element (PE) to a port of the HNoC switch fabric. On the transmit path it turns PE payload words plus a destination into address-tagged flits for the switch. On the receive path it accepts flits from the switch, checks that each one is addressed to this endpoint, and delivers the payload to the PE. Misrouted flits are discarded. Both directions are fully registered and use valid/ready handshakes, with one 2-entry skid buffer per direction.

## Interface
- DataWidth, 36, flit width; the destination field is the top AddrWidth bits.
- AddrWidth, 4, destination field width.
- MyAddr, 0, this endpoint's network address.
- StatWidth, 16, statistics counter width (used only with NOC_EP_STATS_EN).

Ports (PW = DataWidth-AddrWidth):
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_pe_data  in  PW  TX payload from the PE.
- i_pe_dest  in  AddrWidth  TX destination address.
- i_pe_valid  in  1  TX payload valid.
- o_pe_ready  out  1  endpoint can accept a TX payload.
- o_data  out  DataWidth  flit to the switch, {dest, payload}.
- o_data_valid  out  1  flit valid.
- i_data_ready  in  1  switch accepts the flit.
- i_data  in  DataWidth  flit from the switch.
- i_data_valid  in  1  flit valid.
- o_data_ready  out  1  endpoint accepts the flit.
- o_pe_data  out  PW  RX payload to the PE.
- o_pe_valid  out  1  RX payload valid.
- i_pe_ready  in  1  PE accepts the RX payload.
- o_rx_drop  out  1  one-cycle pulse when a misrouted flit is discarded.

## Operation
- A transfer occurs on any interface in a cycle where valid and ready are both high.
- **TX path:** the flit is `{i_pe_dest, i_pe_data}`. It is written into the TX skid buffer. No checks are made on the destination; a flit addressed to MyAddr is sent unchanged.
- **RX path:** on each accepted flit, compare the top AddrWidth bits with MyAddr.
  - Equal: the low PW bits go into the RX skid buffer.
  - Not equal: the flit is accepted and discarded, and o_rx_drop pulses in the following cycle.
- **Skid buffer:** two states, EMPTY_OR_MAIN and SKID.
  - The main register drives the outputs.
  - When downstream stalls while the main register is valid and a new word arrives, that word goes into the skid register.
  - Upstream ready is driven as NOT(skid valid).
  - When downstream accepts and the skid register is valid, skid moves to main in the same edge.
- Order is preserved within each direction. The TX and RX paths are independent and never stall each other.
- Reset mid-operation: buffer contents are lost; no partial flit is ever emitted.

## Timing
- Latency is 1 cycle from an input transfer to the corresponding output valid, in both directions.
- Throughput is 1 word per cycle when downstream ready is continuously high.
- o_pe_ready and o_data_ready are registered, with no combinational path from i_data_ready or i_pe_ready.
- A dropped flit does not occupy the RX buffer, so RX ready is unaffected by drops.
- Reset values: o_data_valid=0, o_pe_valid=0, o_rx_drop=0, o_pe_ready=0, o_data_ready=0, all data outputs 0.
- Readies rise in the first cycle after i_reset falls.
- Both valids hold while ready is low, and data stays stable while valid is high and ready is low.

## Configuration
- NOC_EP_STATS_EN defined adds three outputs of StatWidth bits:
  - o_tx_count: counts TX flits sent.
  - o_rx_count: counts RX payloads delivered.
  - o_drop_count: counts misrouted flits.
  - All three increment on their respective transfers, saturate at all-ones, and reset to 0.
- NOC_EP_STATS_EN undefined: the ports and counters are absent and the remaining behaviour is identical.

## Structure
- The shared package noc_pkg holds:
  - the constants DATA_WIDTH=36 and ADDR_WIDTH=4;
  - a function extracting the destination field of a flit.
- Sub-module noc_skid_buffer (parameter Width) is instantiated twice: TX with Width=DataWidth, RX with Width=PW.

## Test plan
- Reset, then i_pe_valid=1, dest=5, data=0xDEADBEEF with i_data_ready=1 → next cycle o_data=0x5DEADBEEF, o_data_valid=1.
- i_data=0x0_0000_1234 (MyAddr=0) valid, i_pe_ready=1 → next cycle o_pe_data=0x1234, o_pe_valid=1, o_rx_drop=0.
- i_data=0x3_0000_1234 with MyAddr=0 → o_pe_valid stays 0, o_rx_drop=1 for exactly one cycle, and o_drop_count=1 when stats are enabled.
- Stream 8 TX words with i_data_ready low for cycles 2–4:
  - o_pe_ready drops after 2 words are buffered;
  - all 8 flits emerge in order with no loss or duplication.
- Assert i_reset while both skid buffers are full → next cycle both valids are 0 and both readies are 0; one cycle after release, both readies are 1.
- With NOC_EP_STATS_EN and StatWidth=4, send 20 TX flits → o_tx_count saturates at 15.
